// File: rtl/matriz_op_controller.sv
`default_nettype none
// ============================================================================
// Module      : matriz_op_controller
// Description : Sequencer that loads two 5x5 operand matrices from data
//               memory, runs the combinational matrix ALU and stores the result.
// Revision    : 1.0 - initial release
// ============================================================================
module matriz_op_controller #(
  parameter int N_ELEM = 25,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [OP_W-1:0]            op,
  input  logic [ADDR_W-1:0]          base_a,
  input  logic [ADDR_W-1:0]          base_b,
  input  logic [ADDR_W-1:0]          base_c,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_rd_en,
  input  logic [ELEM_W-1:0]          mem_rdata,
  output logic                       mem_wr_en,
  output logic [ELEM_W-1:0]          mem_wdata,
  output logic [OP_W-1:0]            ula_op,
  output logic [N_ELEM*ELEM_W-1:0]   ula_a,
  output logic [N_ELEM*ELEM_W-1:0]   ula_b,
  input  logic [N_ELEM*ELEM_W-1:0]   ula_result
);

  localparam int C_VEC_W = N_ELEM * ELEM_W;
  localparam int C_CNT_W = $clog2(N_ELEM);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT_B = 3'd3,
    S_EXEC   = 3'd4,
    S_STORE  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [C_CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]    r_base_a;
  logic [ADDR_W-1:0]    r_base_b;
  logic [ADDR_W-1:0]    r_base_c;
  logic [OP_W-1:0]      r_op;
  logic [C_VEC_W-1:0]   r_ula_a;
  logic [C_VEC_W-1:0]   r_ula_b;
  logic [C_VEC_W-1:0]   r_result;

  // Pipeline of the read issued last cycle, used to steer mem_rdata
  logic                 r_rd_v;
  logic                 r_rd_b;
  logic [C_CNT_W-1:0]   r_rd_idx;

  logic                 w_last;
  logic [ADDR_W-1:0]    w_cnt_addr;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_rd_en;
  logic                 w_rd_b;
  logic                 w_wr_en;
  logic [ADDR_W-1:0]    w_addr;
  logic [ELEM_W-1:0]    w_wdata;

  assign w_last     = (r_cnt == C_CNT_W'(N_ELEM - 1));
  assign w_cnt_addr = ADDR_W'(r_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_rd_en = 1'b0;
    w_rd_b  = 1'b0;
    w_wr_en = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        w_busy  = 1'b1;
        w_rd_en = 1'b1;
        w_addr  = r_base_a + w_cnt_addr;
        if (w_last) begin
          w_next = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        w_busy  = 1'b1;
        w_rd_en = 1'b1;
        w_rd_b  = 1'b1;
        w_addr  = r_base_b + w_cnt_addr;
        if (w_last) begin
          w_next = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        w_busy = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_busy = 1'b1;
        w_next = S_STORE;
      end
      S_STORE: begin
        w_busy  = 1'b1;
        w_wr_en = 1'b1;
        w_addr  = r_base_c + w_cnt_addr;
        w_wdata = r_result[int'(r_cnt)*ELEM_W +: ELEM_W];
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Element counter, captured request context and result latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= '0;
            r_op     <= op;
            r_base_a <= base_a;
            r_base_b <= base_b;
            r_base_c <= base_c;
          end
        end
        S_LOAD_A, S_LOAD_B, S_STORE: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        S_EXEC: begin
          r_cnt    <= '0;
          r_result <= ula_result;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Read data lands one cycle after the strobe, independent of FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_v   <= 1'b0;
      r_rd_b   <= 1'b0;
      r_rd_idx <= '0;
      r_ula_a  <= '0;
      r_ula_b  <= '0;
    end else begin
      r_rd_v   <= w_rd_en;
      r_rd_b   <= w_rd_b;
      r_rd_idx <= r_cnt;
      if (r_rd_v) begin
        if (r_rd_b) begin
          r_ula_b[int'(r_rd_idx)*ELEM_W +: ELEM_W] <= mem_rdata;
        end else begin
          r_ula_a[int'(r_rd_idx)*ELEM_W +: ELEM_W] <= mem_rdata;
        end
      end
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign mem_addr  = w_addr;
  assign mem_rd_en = w_rd_en;
  assign mem_wr_en = w_wr_en;
  assign mem_wdata = w_wdata;
  assign ula_op    = r_op;
  assign ula_a     = r_ula_a;
  assign ula_b     = r_ula_b;

endmodule
`default_nettype wire

// File: tb/tb_matriz_op_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_matriz_op_controller
// Description : Scoreboard bench with a memory model and a stub matrix ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matriz_op_controller;

  localparam int N = 25;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [7:0]   base_a, base_b, base_c;
  logic         busy, done;
  logic [7:0]   mem_addr;
  logic         mem_rd_en, mem_wr_en;
  logic [7:0]   mem_rdata = 8'h00;
  logic [7:0]   mem_wdata;
  logic [2:0]   ula_op;
  logic [199:0] ula_a, ula_b, ula_result;

  logic [7:0]   mem [256];

  logic [7:0]   exp_rd[$];
  logic [7:0]   obs_rd[$];
  logic [15:0]  exp_wr[$];
  logic [15:0]  obs_wr[$];
  int           n_both = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  matriz_op_controller dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .ula_op(ula_op), .ula_a(ula_a), .ula_b(ula_b), .ula_result(ula_result)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_el(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb begin
    ula_result = '0;
    for (int i = 0; i < N; i++) begin
      ula_result[i*8 +: 8] = alu_el(ula_op, ula_a[i*8 +: 8], ula_b[i*8 +: 8]);
    end
  end

  // Synchronous-read memory: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Advance to the middle of the next cycle and record memory traffic
  task automatic tick();
    @(negedge clk);
    if (mem_wr_en) begin
      obs_wr.push_back({mem_addr, mem_wdata});
      mem[mem_addr] = mem_wdata;
    end
    if (mem_rd_en) obs_rd.push_back(mem_addr);
    if (mem_rd_en && mem_wr_en) n_both++;
  endtask

  // Drive a start request and push the expected traffic to the scoreboard
  task automatic launch(input logic [2:0] o, input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bc);
    logic [7:0] a_addr, b_addr;
    op = o; base_a = ba; base_b = bb; base_c = bc; start = 1'b1;
    for (int i = 0; i < N; i++) exp_rd.push_back(ba + 8'(i));
    for (int i = 0; i < N; i++) exp_rd.push_back(bb + 8'(i));
    for (int i = 0; i < N; i++) begin
      a_addr = ba + 8'(i);
      b_addr = bb + 8'(i);
      exp_wr.push_back({bc + 8'(i), alu_el(o, mem[a_addr], mem[b_addr])});
    end
  endtask

  task automatic drain(input string tag);
    logic [7:0]  er, orr;
    logic [15:0] ew, ow;
    while (exp_rd.size() > 0 || obs_rd.size() > 0) begin
      n_tests++;
      if (exp_rd.size() == 0) begin
        orr = obs_rd.pop_front(); n_fail++;
        $display("FAIL %s extra_read got addr=%02h required none", tag, orr);
      end else if (obs_rd.size() == 0) begin
        er = exp_rd.pop_front(); n_fail++;
        $display("FAIL %s missing_read got none required addr=%02h", tag, er);
      end else begin
        er = exp_rd.pop_front(); orr = obs_rd.pop_front();
        if (orr !== er) begin
          n_fail++; $display("FAIL %s read_addr got %02h required %02h", tag, orr, er);
        end
      end
    end
    while (exp_wr.size() > 0 || obs_wr.size() > 0) begin
      n_tests++;
      if (exp_wr.size() == 0) begin
        ow = obs_wr.pop_front(); n_fail++;
        $display("FAIL %s extra_write got addr=%02h data=%02h required none", tag, ow[15:8], ow[7:0]);
      end else if (obs_wr.size() == 0) begin
        ew = exp_wr.pop_front(); n_fail++;
        $display("FAIL %s missing_write got none required addr=%02h data=%02h", tag, ew[15:8], ew[7:0]);
      end else begin
        ew = exp_wr.pop_front(); ow = obs_wr.pop_front();
        if (ow !== ew) begin
          n_fail++;
          $display("FAIL %s write got addr=%02h data=%02h required addr=%02h data=%02h",
                   tag, ow[15:8], ow[7:0], ew[15:8], ew[7:0]);
        end
      end
    end
    n_tests++;
    if (n_both != 0) begin
      n_fail++; $display("FAIL %s rd_wr_overlap got %0d cycles required 0", tag, n_both);
    end
    n_both = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; base_a = '0; base_b = '0; base_c = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();
    n_tests++;
    if ({busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, ula_op} !== '0 ||
        ula_a !== '0 || ula_b !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b wr=%b addr=%02h wd=%02h op=%0d required all 0",
               busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, ula_op);
    end
    drain("reset");
  endtask

  task automatic test_sub_basic();
    int bad_busy = 0, bad_done = 0, bad_mem = 0;
    for (int i = 0; i < N; i++) begin mem[8'h00 + i] = 8'd10; mem[8'h20 + i] = 8'd3; end
    launch(3'd1, 8'h00, 8'h20, 8'h40);
    for (int c = 1; c <= 80; c++) begin
      tick(); start = 1'b0;
      if (busy !== (c >= 1 && c <= 78)) bad_busy++;
      if (done !== (c == 78)) bad_done++;
    end
    n_tests++;
    if (bad_busy != 0) begin n_fail++; $display("FAIL sub_busy_window got %0d bad cycles required 0", bad_busy); end
    n_tests++;
    if (bad_done != 0) begin n_fail++; $display("FAIL sub_done_cycle got %0d bad cycles required 0", bad_done); end
    drain("sub_basic");
    for (int i = 0; i < N; i++) if (mem[8'h40 + i] !== 8'd7) bad_mem++;
    n_tests++;
    if (bad_mem != 0) begin n_fail++; $display("FAIL sub_result_mem got %0d wrong elements required 0 (all 7)", bad_mem); end
  endtask

  task automatic test_sub_wrap_order();
    int bad = 0;
    for (int i = 0; i < N; i++) begin mem[8'h00 + i] = 8'd5; mem[8'h20 + i] = 8'd10; end
    launch(3'd1, 8'h00, 8'h20, 8'h60);
    for (int c = 1; c <= 80; c++) begin tick(); start = 1'b0; end
    drain("sub_wrap");
    for (int i = 0; i < N; i++) if (mem[8'h60 + i] !== 8'hFB) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL sub_wrap_mem got %0d wrong elements required 0 (all FB)", bad); end
    bad = 0;
    for (int i = 0; i < N; i++) begin mem[8'h00 + i] = 8'(i); mem[8'h20 + i] = 8'd0; end
    launch(3'd1, 8'h00, 8'h20, 8'hA0);
    for (int c = 1; c <= 80; c++) begin tick(); start = 1'b0; end
    drain("elem_order");
    for (int i = 0; i < N; i++) if (mem[8'hA0 + i] !== 8'(i)) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL elem_order_mem got %0d wrong elements required 0", bad); end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] a;
    for (int i = 0; i < N; i++) begin
      a = 8'hF0 + 8'(i); mem[a] = 8'($urandom);
      a = 8'h80 + 8'(i); mem[a] = 8'($urandom);
    end
    launch(3'd0, 8'hF0, 8'h80, 8'hF8);
    for (int c = 1; c <= 80; c++) begin tick(); start = 1'b0; end
    drain("addr_wrap");
  endtask

  task automatic test_start_ignored();
    int n_done = 0, bad_done = 0;
    for (int i = 0; i < N; i++) begin mem[8'h00 + i] = 8'($urandom); mem[8'h20 + i] = 8'($urandom); end
    launch(3'd2, 8'h00, 8'h20, 8'hC0);
    for (int c = 1; c <= 82; c++) begin
      tick();
      if (done === 1'b1) n_done++;
      start = (c == 10 || c == 78);
      if (c == 79) begin
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after_done got %b required 0", busy); end
      end
    end
    n_tests++;
    if (n_done != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d required 1", n_done); end
    drain("start_ignored");
    launch(3'd0, 8'h20, 8'h00, 8'hD0);
    for (int c = 1; c <= 80; c++) begin
      tick(); start = 1'b0;
      if (done !== (c == 78)) bad_done++;
    end
    n_tests++;
    if (bad_done != 0) begin n_fail++; $display("FAIL restart_done_cycle got %0d bad cycles required 0", bad_done); end
    drain("restart");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) begin mem[8'h00 + i] = 8'($urandom); mem[8'h20 + i] = 8'($urandom); end
    launch(3'd1, 8'h00, 8'h20, 8'h40);
    for (int c = 1; c <= 66; c++) begin
      tick(); start = 1'b0;
      if (c == 59) reset = 1'b1;
      if (c == 60) begin
        reset = 1'b0;
        n_tests++;
        if ({busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, ula_op} !== '0 ||
            ula_a !== '0 || ula_b !== '0) begin
          n_fail++;
          $display("FAIL reset_mid_outputs got busy=%b done=%b rd=%b wr=%b addr=%02h op=%0d required all 0",
                   busy, done, mem_rd_en, mem_wr_en, mem_addr, ula_op);
        end
      end
    end
    n_tests++;
    if (obs_wr.size() != 7) begin n_fail++; $display("FAIL reset_mid_write_count got %0d required 7", obs_wr.size()); end
    while (exp_wr.size() > 7) void'(exp_wr.pop_back());
    drain("reset_mid");
  endtask

  task automatic test_operand_change();
    for (int i = 0; i < N; i++) begin mem[8'h08 + i] = 8'($urandom); mem[8'h30 + i] = 8'($urandom); end
    launch(3'd0, 8'h08, 8'h30, 8'h90);
    for (int c = 1; c <= 80; c++) begin
      tick(); start = 1'b0;
      if (c == 30) begin op = 3'd2; base_a = 8'h55; base_b = 8'h66; base_c = 8'h77; end
      if (c == 52) begin
        n_tests++;
        if (ula_op !== 3'd0) begin n_fail++; $display("FAIL change_ula_op got %0d required 0", ula_op); end
      end
    end
    drain("operand_change");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_sub_basic();
    test_sub_wrap_order();
    test_addr_wrap();
    test_start_ignored();
    test_reset_mid();
    test_operand_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
